usb_pkt_tx: RTL and testbench

Generalised USB packet transmitter that serialises TOKEN, SOF, HANDSHAKE and DATA packets into the byte stream consumed by control_t. It computes CRC5 for TOKEN and SOF and CRC16 for DATA payloads, and reports the PID to link_control. It sits between the transfer layer and control_t, replacing the token/handshake-only CRC5 transmitter.

---
 rtl/usb_pkt_tx.sv | 192 +++++++++++++++++++
 tb/tb_usb_pkt_tx.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_pkt_tx.sv
// USB packet transmitter: serialises TOKEN, SOF, HANDSHAKE and DATA packets into the byte
// stream for control_t, appending CRC5 (TOKEN/SOF) or CRC16 (DATA).
module usb_pkt_tx #(
    parameter int unsigned MAX_LEN = 1023,
    parameter int unsigned LEN_W   = 10,
    parameter bit          SOF_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  tx_pid,
    input  logic [6:0]  tx_addr,
    input  logic [3:0]  tx_endp,
    input  logic [10:0] tx_frame,
    input  logic        tx_zlp,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_dat,
    input  logic        tx_dat_valid,
    input  logic        tx_dat_last,
    output logic        tx_dat_ready,
    output logic        tx_to_sop,
    output logic        tx_to_eop,
    output logic        tx_to_valid,
    input  logic        tx_to_ready,
    output logic [7:0]  tx_to_data,
    output logic        tx_con_pid_en,
    output logic [3:0]  tx_con_pid,
    output logic        tx_err
);

    typedef enum logic [2:0] {StIdle, StPid, StTk1, StTk2, StDat, StCrcl, StCrch} state_e;

    // Both CRCs are kept bit-reflected so that bit 0 of the register is the coefficient
    // sent first on the wire; the complement of the register is then the field as sent.
    function automatic logic [4:0] crc5_upd(input logic [4:0] crc, input logic [10:0] f);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ f[i]) c = (c >> 1) ^ 5'h14;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        pid_q, pid_d;
    logic [10:0]       field_q, field_d;
    logic              zlp_q, zlp_d;
    logic [4:0]        crc5_q, crc5_d;
    logic [15:0]       crc16_q, crc16_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              pid_en_q, pid_en_d;
    logic              err_q, err_d;

    logic              is_sof;
    logic              unsup;
    logic [10:0]       field_in;
    logic              at_max;

    assign is_sof   = (tx_pid == 4'b0101);
    assign unsup    = (tx_pid[1:0] == 2'b00) || (is_sof && !SOF_EN);
    assign field_in = is_sof ? tx_frame : {tx_endp, tx_addr};
    assign at_max   = (cnt_q == LEN_W'(MAX_LEN - 1));

    assign tx_con_pid_en = pid_en_q;
    assign tx_con_pid    = pid_q;
    assign tx_err        = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pid_q    <= '0;
            field_q  <= '0;
            zlp_q    <= 1'b0;
            crc5_q   <= 5'h1F;
            crc16_q  <= 16'hFFFF;
            cnt_q    <= '0;
            pid_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pid_q    <= pid_d;
            field_q  <= field_d;
            zlp_q    <= zlp_d;
            crc5_q   <= crc5_d;
            crc16_q  <= crc16_d;
            cnt_q    <= cnt_d;
            pid_en_q <= pid_en_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        field_d      = field_q;
        zlp_d        = zlp_q;
        crc5_d       = crc5_q;
        crc16_d      = crc16_q;
        cnt_d        = cnt_q;
        pid_en_d     = pid_en_q;
        err_d        = 1'b0;
        tx_ready     = 1'b0;
        tx_to_valid  = 1'b0;
        tx_to_sop    = 1'b0;
        tx_to_eop    = 1'b0;
        tx_to_data   = {~pid_q, pid_q};
        tx_dat_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    pid_d   = tx_pid;
                    field_d = field_in;
                    zlp_d   = tx_zlp;
                    crc5_d  = crc5_upd(5'h1F, field_in);
                    crc16_d = 16'hFFFF;
                    cnt_d   = '0;
                    if (unsup) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = StPid;
                        pid_en_d = 1'b1;
                    end
                end
            end
            StPid: begin
                tx_to_valid = 1'b1;
                tx_to_sop   = 1'b1;
                tx_to_eop   = (pid_q[1:0] == 2'b10);
                if (tx_to_ready) begin
                    pid_en_d = 1'b0;
                    case (pid_q[1:0])
                        2'b10:   state_d = StIdle;
                        2'b11:   state_d = zlp_q ? StCrcl : StDat;
                        default: state_d = StTk1;
                    endcase
                end
            end
            StTk1: begin
                tx_to_valid = 1'b1;
                tx_to_data  = field_q[7:0];
                if (tx_to_ready) state_d = StTk2;
            end
            StTk2: begin
                tx_to_valid = 1'b1;
                tx_to_eop   = 1'b1;
                tx_to_data  = {~crc5_q, field_q[10:8]};
                if (tx_to_ready) state_d = StIdle;
            end
            StDat: begin
                tx_to_valid  = tx_dat_valid;
                tx_to_data   = tx_dat;
                tx_dat_ready = tx_to_ready;
                if (tx_dat_valid && tx_to_ready) begin
                    crc16_d = crc16_upd(crc16_q, tx_dat);
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (tx_dat_last) begin
                        state_d = StCrcl;
                    end else if (at_max) begin
                        err_d   = 1'b1;
                        state_d = StCrcl;
                    end
                end
            end
            StCrcl: begin
                tx_to_valid = 1'b1;
                tx_to_data  = ~crc16_q[7:0];
                if (tx_to_ready) state_d = StCrch;
            end
            StCrch: begin
                tx_to_valid = 1'b1;
                tx_to_eop   = 1'b1;
                tx_to_data  = ~crc16_q[15:8];
                if (tx_to_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_usb_pkt_tx.sv
// Directed bench for usb_pkt_tx: instance a uses default parameters, instance b uses
// MAX_LEN=4 and SOF_EN=0; use_b routes stimulus and observation to one of them.
module tb_usb_pkt_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_addr;
    logic [3:0]  tx_endp;
    logic [10:0] tx_frame;
    logic        tx_zlp, tx_valid, tx_dat_valid, tx_dat_last, tx_to_ready, use_b;
    logic [7:0]  tx_dat;

    logic        a_ready, a_dat_ready, a_sop, a_eop, a_valid, a_pid_en, a_err;
    logic [7:0]  a_data;
    logic [3:0]  a_pid;
    logic        b_ready, b_dat_ready, b_sop, b_eop, b_valid, b_pid_en, b_err;
    logic [7:0]  b_data;
    logic [3:0]  b_pid;

    logic        m_ready, m_dat_ready, m_sop, m_eop, m_valid, m_pid_en, m_err;
    logic [7:0]  m_data;
    logic [3:0]  m_pid;

    logic        valid_a, valid_b, dat_valid_a, dat_valid_b;
    assign valid_a     = tx_valid && !use_b;
    assign valid_b     = tx_valid && use_b;
    assign dat_valid_a = tx_dat_valid && !use_b;
    assign dat_valid_b = tx_dat_valid && use_b;

    assign m_ready     = use_b ? b_ready     : a_ready;
    assign m_dat_ready = use_b ? b_dat_ready : a_dat_ready;
    assign m_sop       = use_b ? b_sop       : a_sop;
    assign m_eop       = use_b ? b_eop       : a_eop;
    assign m_valid     = use_b ? b_valid     : a_valid;
    assign m_pid_en    = use_b ? b_pid_en    : a_pid_en;
    assign m_err       = use_b ? b_err       : a_err;
    assign m_data      = use_b ? b_data      : a_data;
    assign m_pid       = use_b ? b_pid       : a_pid;

    usb_pkt_tx dut_a (
        .clk(clk), .rst_n(rst_n), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_frame(tx_frame), .tx_zlp(tx_zlp), .tx_valid(valid_a), .tx_ready(a_ready),
        .tx_dat(tx_dat), .tx_dat_valid(dat_valid_a), .tx_dat_last(tx_dat_last),
        .tx_dat_ready(a_dat_ready), .tx_to_sop(a_sop), .tx_to_eop(a_eop),
        .tx_to_valid(a_valid), .tx_to_ready(tx_to_ready), .tx_to_data(a_data),
        .tx_con_pid_en(a_pid_en), .tx_con_pid(a_pid), .tx_err(a_err)
    );

    usb_pkt_tx #(.MAX_LEN(4), .LEN_W(3), .SOF_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_frame(tx_frame), .tx_zlp(tx_zlp), .tx_valid(valid_b), .tx_ready(b_ready),
        .tx_dat(tx_dat), .tx_dat_valid(dat_valid_b), .tx_dat_last(tx_dat_last),
        .tx_dat_ready(b_dat_ready), .tx_to_sop(b_sop), .tx_to_eop(b_eop),
        .tx_to_valid(b_valid), .tx_to_ready(tx_to_ready), .tx_to_data(b_data),
        .tx_con_pid_en(b_pid_en), .tx_con_pid(b_pid), .tx_err(b_err)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] q_data[$];
    bit         q_sop[$];
    bit         q_eop[$];
    int         err_cnt, pid_en_cnt, dat_rdy_cnt;

    logic [7:0] pay[0:7];
    int         pay_n, pay_idx;
    bit         last_en;

    // Transfers complete on the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && tx_to_ready) begin
                q_data.push_back(m_data);
                q_sop.push_back(m_sop);
                q_eop.push_back(m_eop);
            end
            if (m_err)       err_cnt++;
            if (m_pid_en)    pid_en_cnt++;
            if (m_dat_ready) dat_rdy_cnt++;
        end
    end

    function automatic logic [4:0] gold_crc5(input logic [10:0] f);
        logic [4:0] c, r;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (f[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else             c = {c[3:0], 1'b0};
        end
        for (int k = 0; k < 5; k++) r[k] = ~c[4-k];
        return r;
    endfunction

    // Returns {CRCH, CRCL} as the bytes appear on the stream.
    function automatic logic [15:0] gold_crc16(input int n);
        logic [15:0] c;
        logic [7:0]  lo, hi;
        c = 16'hFFFF;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < 8; j++) begin
                if (pay[b][j] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
                else                   c = {c[14:0], 1'b0};
            end
        end
        for (int k = 0; k < 8; k++) begin
            lo[k] = ~c[15-k];
            hi[k] = ~c[7-k];
        end
        return {hi, lo};
    endfunction

    function automatic logic [63:0] pack_bytes();
        logic [63:0] r = '0;
        foreach (q_data[i]) r = {r[55:0], q_data[i]};
        return r;
    endfunction

    function automatic logic [7:0] pack_flags(input bit eop);
        logic [7:0] r = '0;
        foreach (q_data[i]) r = {r[6:0], eop ? q_eop[i] : q_sop[i]};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_sop.delete();
        q_eop.delete();
        err_cnt = 0;
        pid_en_cnt = 0;
        dat_rdy_cnt = 0;
    endtask

    task automatic request(input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] endp, input logic [10:0] frame, input logic zlp);
        tx_pid = pid;
        tx_addr = addr;
        tx_endp = endp;
        tx_frame = frame;
        tx_zlp = zlp;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic run(input int n, input bit toggle);
        bit acc;
        for (int i = 0; i < n; i++) begin
            tx_dat_valid = (pay_idx < pay_n);
            if (pay_idx < pay_n) tx_dat = pay[pay_idx];
            tx_dat_last = last_en && (pay_idx == pay_n - 1);
            @(negedge clk);
            acc = tx_dat_valid && m_dat_ready;
            step();
            if (acc) pay_idx++;
            if (toggle) tx_to_ready = ~tx_to_ready;
        end
        tx_dat_valid = 1'b0;
        tx_dat_last = 1'b0;
        tx_to_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [18:0] got;
        rst_n = 1'b0;
        repeat (2) step();
        got = {m_ready, m_valid, m_sop, m_eop, m_data, m_pid_en, m_pid, m_dat_ready, m_err};
        n_total++;
        if (got !== {4'b1000, 8'hF0, 1'b0, 4'h0, 2'b00})
            $display("FAIL reset_outputs: got %h want %h", got, {4'b1000, 8'hF0, 7'h00});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_token();
        logic [7:0] tk2;
        tk2 = {gold_crc5({4'hE, 7'h15}), 3'b111};
        request(4'b0001, 7'h15, 4'hE, 11'h0, 1'b0);
        n_total++;
        if ({m_valid, m_sop, m_eop, m_data, m_ready, m_pid_en} !== {3'b110, 8'hE1, 2'b01})
            $display("FAIL tok_pid: got v%b s%b e%b %h rdy%b pe%b want v1 s1 e0 e1 rdy0 pe1",
                     m_valid, m_sop, m_eop, m_data, m_ready, m_pid_en);
        else n_pass++;
        step();
        n_total++;
        if ({m_valid, m_sop, m_eop, m_data, m_pid_en} !== {3'b100, 8'h15, 1'b0})
            $display("FAIL tok_tk1: got v%b s%b e%b %h pe%b want v1 s0 e0 15 pe0",
                     m_valid, m_sop, m_eop, m_data, m_pid_en);
        else n_pass++;
        step();
        n_total++;
        if ({m_valid, m_sop, m_eop, m_data} !== {3'b101, tk2})
            $display("FAIL tok_tk2: got v%b s%b e%b %h want v1 s0 e1 %h",
                     m_valid, m_sop, m_eop, m_data, tk2);
        else n_pass++;
        step();
        n_total++;
        if ({m_ready, m_valid, m_eop} !== 3'b100)
            $display("FAIL tok_done: got rdy%b v%b e%b want rdy1 v0 e0", m_ready, m_valid, m_eop);
        else n_pass++;
    endtask

    task automatic test_ack();
        clear_mon();
        request(4'b0010, 7'h0, 4'h0, 11'h0, 1'b0);
        run(4, 1'b0);
        n_total++;
        if (q_data.size() != 1 || pack_bytes() !== 64'hD2 || pack_flags(1) !== 8'h1
            || pack_flags(0) !== 8'h1)
            $display("FAIL ack_bytes: got n=%0d %h want n=1 d2 with sop/eop",
                     q_data.size(), pack_bytes());
        else n_pass++;
        n_total++;
        if (pid_en_cnt != 1 || m_pid !== 4'h2)
            $display("FAIL ack_pid_en: got %0d cycles pid %h want 1 cycle pid 2",
                     pid_en_cnt, m_pid);
        else n_pass++;
    endtask

    task automatic test_zlp();
        clear_mon();
        request(4'b0011, 7'h0, 4'h0, 11'h0, 1'b1);
        run(6, 1'b0);
        n_total++;
        if (q_data.size() != 3 || pack_bytes() !== 64'hC30000 || pack_flags(1) !== 8'b001)
            $display("FAIL zlp_bytes: got n=%0d %h eop %b want n=3 c30000 eop 001",
                     q_data.size(), pack_bytes(), pack_flags(1));
        else n_pass++;
        n_total++;
        if (dat_rdy_cnt != 0)
            $display("FAIL zlp_dat_ready: got %0d cycles want 0", dat_rdy_cnt);
        else n_pass++;
    endtask

    task automatic test_data_toggle();
        logic [15:0] c16;
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) pay[i] = 8'(i);
        pay_n = 4;
        pay_idx = 0;
        last_en = 1'b1;
        c16 = gold_crc16(4);
        exp = {8'h00, 8'h4B, 32'h00010203, c16[7:0], c16[15:8]};
        clear_mon();
        request(4'b1011, 7'h0, 4'h0, 11'h0, 1'b0);
        run(30, 1'b1);
        n_total++;
        if (q_data.size() != 7 || pack_bytes() !== exp)
            $display("FAIL data_bytes: got n=%0d %h want n=7 %h", q_data.size(), pack_bytes(), exp);
        else n_pass++;
        n_total++;
        if (pack_flags(0) !== 8'b1000000 || pack_flags(1) !== 8'b0000001)
            $display("FAIL data_flags: got sop %b eop %b want 1000000 0000001",
                     pack_flags(0), pack_flags(1));
        else n_pass++;
        n_total++;
        if (pay_idx != 4 || err_cnt != 0 || m_ready !== 1'b1)
            $display("FAIL data_done: got taken %0d err %0d rdy %b want 4 0 1",
                     pay_idx, err_cnt, m_ready);
        else n_pass++;
    endtask

    task automatic test_overrun();
        logic [15:0] c16;
        logic [63:0] exp;
        for (int i = 0; i < 6; i++) pay[i] = 8'h10 + 8'(i);
        pay_n = 6;
        pay_idx = 0;
        last_en = 1'b0;
        c16 = gold_crc16(4);
        exp = {8'h00, 8'hC3, 32'h10111213, c16[7:0], c16[15:8]};
        use_b = 1'b1;
        clear_mon();
        request(4'b0011, 7'h0, 4'h0, 11'h0, 1'b0);
        run(20, 1'b0);
        n_total++;
        if (q_data.size() != 7 || pack_bytes() !== exp || pack_flags(1) !== 8'b0000001)
            $display("FAIL ovr_bytes: got n=%0d %h eop %b want n=7 %h eop 0000001",
                     q_data.size(), pack_bytes(), pack_flags(1), exp);
        else n_pass++;
        n_total++;
        if (err_cnt != 1)
            $display("FAIL ovr_err: got %0d pulses want 1", err_cnt);
        else n_pass++;
        n_total++;
        if (pay_idx != 4 || dat_rdy_cnt != 4)
            $display("FAIL ovr_dat_ready: got taken %0d ready %0d want 4 4", pay_idx, dat_rdy_cnt);
        else n_pass++;
        use_b = 1'b0;
    endtask

    task automatic test_unsupported();
        clear_mon();
        request(4'b0000, 7'h0, 4'h0, 11'h0, 1'b0);
        n_total++;
        if (m_err !== 1'b1 || m_ready !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL unsup_pulse: got err%b rdy%b v%b want err1 rdy1 v0",
                     m_err, m_ready, m_valid);
        else n_pass++;
        step();
        n_total++;
        if (m_err !== 1'b0)
            $display("FAIL unsup_pulse_end: got err%b want err0", m_err);
        else n_pass++;
        run(3, 1'b0);
        n_total++;
        if (q_data.size() != 0 || err_cnt != 1)
            $display("FAIL unsup_quiet: got %0d bytes %0d pulses want 0 1",
                     q_data.size(), err_cnt);
        else n_pass++;
        use_b = 1'b1;
        clear_mon();
        request(4'b0101, 7'h0, 4'h0, 11'h710, 1'b0);
        run(4, 1'b0);
        n_total++;
        if (q_data.size() != 0 || err_cnt != 1 || m_ready !== 1'b1)
            $display("FAIL sof_disabled: got %0d bytes %0d pulses rdy%b want 0 1 1",
                     q_data.size(), err_cnt, m_ready);
        else n_pass++;
        use_b = 1'b0;
    endtask

    task automatic test_sof();
        logic [63:0] exp;
        exp = {40'h0, 8'hA5, 8'h10, gold_crc5(11'h710), 3'b111};
        clear_mon();
        request(4'b0101, 7'h0, 4'h0, 11'h710, 1'b0);
        run(5, 1'b0);
        n_total++;
        if (q_data.size() != 3 || pack_bytes() !== exp || pack_flags(1) !== 8'b001)
            $display("FAIL sof_bytes: got n=%0d %h eop %b want n=3 %h eop 001",
                     q_data.size(), pack_bytes(), pack_flags(1), exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        tx_pid = 4'b0010;
        tx_valid = 1'b1;
        repeat (6) step();
        tx_valid = 1'b0;
        run(3, 1'b0);
        n_total++;
        if (q_data.size() != 3 || pack_bytes() !== 64'hD2D2D2 || pid_en_cnt != 3)
            $display("FAIL b2b_ack: got n=%0d %h pe %0d want n=3 d2d2d2 pe 3",
                     q_data.size(), pack_bytes(), pid_en_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [18:0] got;
        request(4'b1001, 7'h15, 4'hE, 11'h0, 1'b0);
        step();
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 8'h15)
            $display("FAIL mid_tk1: got v%b %h want v1 15", m_valid, m_data);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        got = {m_ready, m_valid, m_sop, m_eop, m_data, m_pid_en, m_pid, m_dat_ready, m_err};
        n_total++;
        if (got !== {4'b1000, 8'hF0, 1'b0, 4'h0, 2'b00})
            $display("FAIL mid_reset: got %h want %h", got, {4'b1000, 8'hF0, 7'h00});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        clear_mon();
        run(3, 1'b0);
        n_total++;
        if (q_data.size() != 0 || m_ready !== 1'b1)
            $display("FAIL mid_after: got %0d bytes rdy%b want 0 1", q_data.size(), m_ready);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        tx_pid = '0;
        tx_addr = '0;
        tx_endp = '0;
        tx_frame = '0;
        tx_zlp = 1'b0;
        tx_valid = 1'b0;
        tx_dat = '0;
        tx_dat_valid = 1'b0;
        tx_dat_last = 1'b0;
        tx_to_ready = 1'b1;
        use_b = 1'b0;
        pay_n = 0;
        pay_idx = 0;
        last_en = 1'b0;
        for (int i = 0; i < 8; i++) pay[i] = '0;
        clear_mon();
        test_reset();
        test_token();
        test_ack();
        test_zlp();
        test_data_toggle();
        test_overrun();
        test_unsupported();
        test_sof();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
